// File: rtl/count_sequencer.sv
// count_sequencer: controls an external 4-bit mod-16 counter through a clear/tick interface.
//
// A run is requested with start while idle. The sequencer first clears the counter for one
// cycle, then ticks it up to the latched limit. In one-shot mode it finishes with a single-cycle
// done pulse; in continuous mode it clears the counter on reaching the limit, counts the wrap and
// keeps running until stopped.
//
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   start    - request a run (only honoured in IDLE and when stop is low)
//   stop     - abort the current run (highest priority)
//   hold     - freeze counting, terminal detection and wrap while high
//   mode     - 0 = one-shot, 1 = continuous; latched at start
//   limit    - terminal count value; latched at start
//   count    - current value of the controlled counter
//   cnt_clr  - synchronous clear request to the counter (wins over cnt_tick)
//   cnt_tick - increment request to the counter
//   busy     - high while clearing or running
//   done     - registered one-cycle completion / wrap pulse
//   wraps    - saturating number of wraps since the last start

module count_sequencer #(
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic              mode,
    input  logic [3:0]        limit,
    input  logic [3:0]        count,
    output logic              cnt_clr,
    output logic              cnt_tick,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        lim_q, lim_d;
    logic              mode_q, mode_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              done_q, done_d;

    logic terminal;
    logic wraps_max;

    // An out-of-range count (above lim_q) is simply non-terminal, so the counter keeps ticking
    // and wraps through zero until it meets the limit.
    assign terminal  = (count == lim_q);
    assign wraps_max = &wraps_q;

    always_comb begin
        state_d  = state_q;
        lim_d    = lim_q;
        mode_d   = mode_q;
        wraps_d  = wraps_q;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_tick = 1'b0;
        busy     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    lim_d   = limit;
                    mode_d  = mode;
                    wraps_d = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                busy    = 1'b1;
                cnt_clr = 1'b1;
                state_d = stop ? StIdle : StRun;
            end
            StRun: begin
                busy = 1'b1;
                // Priority: stop > hold > terminal action > tick.
                if (stop) begin
                    state_d = StIdle;
                end else if (hold) begin
                    // everything frozen
                end else if (terminal) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        cnt_clr = 1'b1;
                        if (!wraps_max) begin
                            wraps_d = wraps_q + WRAP_W'(1);
                        end
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_tick = 1'b1;
                end
            end
            StDone: begin
                // start is deliberately not sampled here
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            lim_q   <= 4'd0;
            mode_q  <= 1'b0;
            wraps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            wraps_q <= wraps_d;
            done_q  <= done_d;
        end
    end

    assign done  = done_q;
    assign wraps = wraps_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus a randomized run against a
// behavioural model. Two instances (default and 2-bit wrap counter) share all inputs and each
// drives its own external counter model.

module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, hold, mode;
    logic [3:0] limit;
    logic [3:0] count, count2;
    logic       force_en;
    logic [3:0] force_val;

    logic       cnt_clr, cnt_tick, busy, done;
    logic       cnt_clr2, cnt_tick2, busy2, done2;
    logic [7:0] wraps;
    logic [1:0] wraps2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    count_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .mode     (mode),
        .limit    (limit),
        .count    (count),
        .cnt_clr  (cnt_clr),
        .cnt_tick (cnt_tick),
        .busy     (busy),
        .done     (done),
        .wraps    (wraps)
    );

    count_sequencer #(.WRAP_W(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .mode     (mode),
        .limit    (limit),
        .count    (count2),
        .cnt_clr  (cnt_clr2),
        .cnt_tick (cnt_tick2),
        .busy     (busy2),
        .done     (done2),
        .wraps    (wraps2)
    );

    // External counters: clear wins over tick; force_en loads a value (fault injection / init).
    always @(posedge clk) begin
        if (force_en)      count <= force_val;
        else if (cnt_clr)  count <= 4'd0;
        else if (cnt_tick) count <= count + 4'd1;
    end

    always @(posedge clk) begin
        if (force_en)       count2 <= force_val;
        else if (cnt_clr2)  count2 <= 4'd0;
        else if (cnt_tick2) count2 <= count2 + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        start = 1'b0;
        hold  = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
    endtask

    // Returns one cycle after the edge that samples start (cycle j = 0, CLEAR).
    task automatic launch(input logic m, input logic [3:0] l);
        mode  = m;
        limit = l;
        start = 1'b1;
        stop  = 1'b0;
        hold  = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0; limit = 4'd0;
        force_en = 1'b1; force_val = 4'd5;
        tick();
        tick();
        vectors++;
        if ({cnt_clr, cnt_tick, busy, done, wraps} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got clr=%b tick=%b busy=%b done=%b wraps=%0d exp all 0",
                     cnt_clr, cnt_tick, busy, done, wraps);
        end
        reset = 1'b1;
        force_en = 1'b0;
        tick();
        vectors++;
        if ({busy, done, count} !== {1'b0, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b count=%0d exp 0 0 5",
                     busy, done, count);
        end
        // start together with stop in IDLE is not a valid request
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        #1;
        vectors++;
        if ({busy, cnt_clr} !== 2'b00) begin
            errors++;
            $display("FAIL start_with_stop got busy=%b clr=%b exp 0 0", busy, cnt_clr);
        end
        tick();
    endtask

    task automatic test_one_shot();
        int exp_cnt;
        force_en = 1'b1; force_val = 4'd9;
        tick();
        force_en = 1'b0;
        launch(1'b0, 4'd3);
        // latched values must not follow the inputs during the run
        limit = 4'($urandom_range(15, 4));
        mode  = 1'b1;
        for (int j = 0; j <= 7; j++) begin
            #1;
            vectors++;
            if ({busy, done} !== {(j <= 4), (j == 5)}) begin
                errors++;
                $display("FAIL one_shot_busy_done j=%0d got %b%b exp %b%b",
                         j, busy, done, (j <= 4), (j == 5));
            end
            if (j >= 1) begin
                exp_cnt = (j - 1 < 3) ? j - 1 : 3;
                vectors++;
                if (count !== 4'(exp_cnt)) begin
                    errors++;
                    $display("FAIL one_shot_count j=%0d got %0d exp %0d", j, count, exp_cnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_continuous();
        int n_done = 0;
        launch(1'b1, 4'd2);
        for (int j = 0; j <= 10; j++) begin
            #1;
            if (j >= 1) begin
                vectors++;
                if ({count, done, cnt_clr} !==
                    {4'((j - 1) % 3), (j > 1 && (j - 1) % 3 == 0), ((j - 1) % 3 == 2)}) begin
                    errors++;
                    $display("FAIL continuous j=%0d got count=%0d done=%b clr=%b exp %0d %b %b",
                             j, count, done, cnt_clr, (j - 1) % 3,
                             (j > 1 && (j - 1) % 3 == 0), ((j - 1) % 3 == 2));
                end
                n_done += int'(done);
            end
            tick();
        end
        vectors++;
        if (n_done != 3 || wraps !== 8'd3) begin
            errors++;
            $display("FAIL continuous_wraps got pulses=%0d wraps=%0d exp 3 3", n_done, wraps);
        end
        stop = 1'b1;
        #1;
        vectors++;
        if (cnt_tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_tick got %b exp 0", cnt_tick);
        end
        tick();
        stop = 1'b0;
        #1;
        vectors++;
        if ({busy, done, count} !== {1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL stop_abort got busy=%b done=%b count=%0d exp 0 0 1", busy, done, count);
        end
        tick();
    endtask

    task automatic test_hold();
        int exp_cnt;
        launch(1'b0, 4'd5);
        for (int j = 0; j <= 12; j++) begin
            hold = (j >= 3 && j <= 6);
            #1;
            if (j >= 1) begin
                exp_cnt = (j <= 3) ? j - 1 : (j <= 7) ? 2 : ((j - 5 < 5) ? j - 5 : 5);
                vectors++;
                if ({count, done} !== {4'(exp_cnt), (j == 11)}) begin
                    errors++;
                    $display("FAIL hold j=%0d got count=%0d done=%b exp %0d %b",
                             j, count, done, exp_cnt, (j == 11));
                end
            end
            if (hold) begin
                vectors++;
                if (cnt_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_tick j=%0d got %b exp 0", j, cnt_tick);
                end
            end
            tick();
        end
        hold = 1'b0;
    endtask

    task automatic test_stop_hold();
        launch(1'b0, 4'd9);
        for (int j = 0; j <= 7; j++) begin
            stop = (j == 5);
            hold = (j == 5);
            #1;
            if (j >= 1 && j <= 5) begin
                vectors++;
                if (count !== 4'(j - 1)) begin
                    errors++;
                    $display("FAIL stop_hold_count j=%0d got %0d exp %0d", j, count, j - 1);
                end
            end
            if (j == 5) begin
                vectors++;
                if ({cnt_tick, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL stop_hold_cycle got tick=%b busy=%b exp 0 1", cnt_tick, busy);
                end
            end
            if (j >= 6) begin
                vectors++;
                if ({busy, done, cnt_clr, count} !== {3'b000, 4'd4}) begin
                    errors++;
                    $display("FAIL stop_hold_idle j=%0d got busy=%b done=%b clr=%b count=%0d exp 0 0 0 4",
                             j, busy, done, cnt_clr, count);
                end
            end
            tick();
        end
        stop = 1'b0;
        hold = 1'b0;
    endtask

    task automatic test_wrap_sat();
        int exp_w;
        launch(1'b1, 4'd0);
        for (int j = 0; j <= 7; j++) begin
            if (j == 3) limit = 4'd7;
            stop = (j == 7);
            #1;
            exp_w = (j == 0) ? 0 : j - 1;
            vectors++;
            if (wraps !== 8'(exp_w) || wraps2 !== 2'((exp_w < 3) ? exp_w : 3)) begin
                errors++;
                $display("FAIL wrap_sat j=%0d got wraps=%0d wraps2=%0d exp %0d %0d",
                         j, wraps, wraps2, exp_w, (exp_w < 3) ? exp_w : 3);
            end
            if (j >= 1 && j <= 6) begin
                vectors++;
                if ({cnt_clr, busy, count, done} !== {2'b11, 4'd0, (j >= 2)}) begin
                    errors++;
                    $display("FAIL wrap_every_cycle j=%0d got clr=%b busy=%b count=%0d done=%b",
                             j, cnt_clr, busy, count, done);
                end
            end
            if (j == 7) begin
                vectors++;
                if (cnt_clr !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_stop_clr got %b exp 0", cnt_clr);
                end
            end
            tick();
        end
        stop = 1'b0;
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_stop_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        launch(1'b0, 4'd9);
        for (int j = 0; j <= 6; j++) tick();
        #1;
        vectors++;
        if ({count, busy} !== {4'd6, 1'b1}) begin
            errors++;
            $display("FAIL mid_run_pre got count=%0d busy=%b exp 6 1", count, busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({cnt_clr, cnt_tick, busy, done, wraps} !== 12'd0) begin
            errors++;
            $display("FAIL mid_run_reset got clr=%b tick=%b busy=%b done=%b wraps=%0d exp 0",
                     cnt_clr, cnt_tick, busy, done, wraps);
        end
        tick();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy, done, count} !== {2'b00, 4'd6}) begin
            errors++;
            $display("FAIL mid_run_after got busy=%b done=%b count=%0d exp 0 0 6", busy, done, count);
        end
        // start held high throughout: ignored while busy and in DONE
        launch(1'b0, 4'd1);
        start = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            #1;
            if (j == 1) begin
                vectors++;
                if ({cnt_clr, cnt_tick} !== 2'b01) begin
                    errors++;
                    $display("FAIL start_busy1 got clr=%b tick=%b exp 0 1", cnt_clr, cnt_tick);
                end
            end
            if (j == 2) begin
                vectors++;
                if ({count, cnt_clr} !== {4'd1, 1'b0}) begin
                    errors++;
                    $display("FAIL start_busy2 got count=%0d clr=%b exp 1 0", count, cnt_clr);
                end
            end
            if (j == 3) begin
                vectors++;
                if ({done, busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL start_in_done got done=%b busy=%b exp 1 0", done, busy);
                end
            end
            if (j == 4) begin
                vectors++;
                if ({done, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL after_done got done=%b busy=%b exp 0 0", done, busy);
                end
            end
            if (j == 5) begin
                vectors++;
                if ({busy, cnt_clr} !== 2'b11) begin
                    errors++;
                    $display("FAIL restart got busy=%b clr=%b exp 1 1", busy, cnt_clr);
                end
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_fault_count();
        launch(1'b0, 4'd3);
        for (int j = 0; j <= 10; j++) begin
            force_en  = (j == 1);
            force_val = 4'd13;
            #1;
            if (j >= 2 && j <= 8) begin
                vectors++;
                if ({count, cnt_tick} !== {4'((13 + j - 2) % 16), (j <= 7)}) begin
                    errors++;
                    $display("FAIL fault_count j=%0d got count=%0d tick=%b exp %0d %b",
                             j, count, cnt_tick, (13 + j - 2) % 16, (j <= 7));
                end
            end
            vectors++;
            if (done !== (j == 9)) begin
                errors++;
                $display("FAIL fault_done j=%0d got %b exp %b", j, done, (j == 9));
            end
            tick();
        end
        force_en = 1'b0;
    endtask

    task automatic test_random();
        bit m_clearing, m_running, m_done, m_mode;
        int m_lim, m_count, m_wraps;
        bit n_clearing, n_running, n_done, n_mode;
        int n_lim, n_count, n_wraps;
        bit e_clr, e_tick, e_busy, e_done;
        int e_w8, e_w2;

        // synchronise model and DUTs from a known point
        reset = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
        force_en = 1'b1; force_val = 4'd0;
        tick();
        reset = 1'b1; force_en = 1'b0;
        m_clearing = 0; m_running = 0; m_done = 0; m_mode = 0;
        m_lim = 0; m_count = 0; m_wraps = 0;

        for (int c = 0; c < 600; c++) begin
            reset = ($urandom % 60 != 0);
            start = ($urandom % 3 == 0);
            stop  = ($urandom % 25 == 0);
            hold  = ($urandom % 6 == 0);
            mode  = 1'($urandom % 2);
            limit = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 5);
            #1;

            e_clr = 0; e_tick = 0;
            e_busy = m_clearing || m_running;
            e_done = m_done;
            n_clearing = 0; n_running = m_running; n_done = 0; n_mode = m_mode;
            n_lim = m_lim; n_count = m_count; n_wraps = m_wraps;

            if (!reset) begin
                e_busy = 0; e_done = 0;
                n_running = 0; n_mode = 0; n_lim = 0; n_wraps = 0;
            end else if (m_clearing) begin
                e_clr = 1;
                n_count = 0;
                n_running = !stop;
            end else if (m_running) begin
                if (stop) begin
                    n_running = 0;
                end else if (!hold) begin
                    if (m_count == m_lim) begin
                        n_done = 1;
                        if (m_mode) begin
                            e_clr = 1;
                            n_count = 0;
                            n_wraps = m_wraps + 1;
                        end else begin
                            n_running = 0;
                        end
                    end else begin
                        e_tick = 1;
                        n_count = (m_count + 1) % 16;
                    end
                end
            end else if (!m_done && start && !stop) begin
                n_clearing = 1;
                n_lim = int'(limit);
                n_mode = mode;
                n_wraps = 0;
            end
            e_w8 = reset ? ((m_wraps < 255) ? m_wraps : 255) : 0;
            e_w2 = reset ? ((m_wraps < 3) ? m_wraps : 3) : 0;

            vectors++;
            if ({cnt_clr, cnt_tick, busy, done, cnt_clr2, cnt_tick2, busy2, done2} !==
                {e_clr, e_tick, e_busy, e_done, e_clr, e_tick, e_busy, e_done}) begin
                errors++;
                $display("FAIL random_ctrl c=%0d got %b%b%b%b/%b%b%b%b exp clr/tick/busy/done %b%b%b%b",
                         c, cnt_clr, cnt_tick, busy, done, cnt_clr2, cnt_tick2, busy2, done2,
                         e_clr, e_tick, e_busy, e_done);
            end
            vectors++;
            if (count !== 4'(m_count) || count2 !== 4'(m_count) ||
                wraps !== 8'(e_w8) || wraps2 !== 2'(e_w2)) begin
                errors++;
                $display("FAIL random_state c=%0d got count=%0d/%0d wraps=%0d/%0d exp %0d %0d/%0d",
                         c, count, count2, wraps, wraps2, m_count, e_w8, e_w2);
            end

            m_clearing = n_clearing; m_running = n_running; m_done = n_done; m_mode = n_mode;
            m_lim = n_lim; m_count = n_count; m_wraps = n_wraps;
            tick();
        end
        reset = 1'b1;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_continuous();
        test_hold();
        test_stop_hold();
        test_wrap_sat();
        test_reset_mid_run();
        test_fault_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WRAP_W, default 8: width of the wrap-event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a counting run; sampled only in IDLE.
REQ-005 SHALL have port stop  input  1  abort the current run.
REQ-006 SHALL have port hold  input  1  pause counting while high.
REQ-007 SHALL have port mode  input  1  0 = one-shot, 1 = continuous (wrap); latched at start.
REQ-008 SHALL have port limit  input  4  terminal count value; latched at start.
REQ-009 SHALL have port count  input  4  current value of the controlled 4-bit counter.
REQ-010 SHALL have port cnt_clr  output  1  synchronous clear to counter; clear has priority over tick.
REQ-011 SHALL have port cnt_tick  output  1  counter increments by 1 mod 16 on the next edge when high.
REQ-012 SHALL have port busy  output  1  high in CLEAR and RUN.
REQ-013 SHALL have port done  output  1  registered one-cycle completion/wrap pulse.
REQ-014 SHALL have port wraps  output  WRAP_W  saturating count of wrap events since start.

Function
REQ-015 SHALL implement states IDLE, CLEAR, RUN, DONE; cnt_clr, cnt_tick and busy decoded combinationally from state, count, hold, stop and latched registers.
REQ-016 IDLE: cnt_clr=0, cnt_tick=0; start=1 and stop=0 -> latch limit into lim_q, mode into mode_q, clear wraps to 0, go CLEAR.
REQ-017 CLEAR: cnt_clr=1 for exactly one cycle; next state RUN (IDLE if stop=1, with cnt_clr still 1).
REQ-018 RUN, non-terminal (count != lim_q): cnt_tick = ~hold & ~stop; state stays RUN.
REQ-019 RUN, terminal, mode_q=0, hold=0: cnt_tick=0, next state DONE; count held at lim_q.
REQ-020 RUN, terminal, mode_q=1, hold=0: cnt_clr=1, cnt_tick=0, wraps increments (saturating at all-ones), done=1 next cycle, state stays RUN.
REQ-021 hold=1 in RUN SHALL suppress tick, terminal detection and wrap; state, count and wraps frozen.
REQ-022 DONE: done=1, busy=0, outputs to counter 0; next state IDLE unconditionally; start ignored in DONE.
REQ-023 stop=1 in CLEAR or RUN SHALL force IDLE on next edge with cnt_tick=0 that cycle, no done pulse; counter value retained.
REQ-024 Priority: stop > hold > terminal action > tick; start ignored while busy.
REQ-025 Changes on limit/mode during a run SHALL have no effect until next start.
REQ-026 One-shot latency: done SHALL be high in the cycle following the (L+2)th rising edge after the edge sampling start, L = latched limit; no hold/stop.
REQ-027 limit=0: one-shot reaches DONE after CLEAR+1 RUN cycle; continuous asserts cnt_clr and wraps every non-held RUN cycle.
REQ-028 Count is 4-bit mod 16; count never exceeds lim_q in a controlled run; if count > lim_q at RUN (external fault) sequencer SHALL keep ticking until wrap reaches lim_q.

Reset
REQ-029 reset low SHALL immediately force state IDLE, lim_q=0, mode_q=0, wraps=0, done=0; hence cnt_clr=0, cnt_tick=0, busy=0.
REQ-030 reset asserted mid-run SHALL abort without done pulse; after release block waits in IDLE for a new start.

Verification
REQ-031 Bench SHALL model the counter per REQ-010/011 and cover: mode=0, limit=3, start pulse at edge E0 -> busy high E0..E5, count 0,1,2,3, done high exactly after E5, count stays 3.
REQ-032 mode=1, limit=2, run 9 RUN cycles -> count sequence 0,1,2,0,1,2,0,1,2, three done pulses, wraps=3.
REQ-033 mode=0, limit=5, hold high 4 cycles when count=2 -> count frozen at 2, done delayed by exactly 4 cycles.
REQ-034 stop and hold asserted together at count=4 (limit=9) -> IDLE next edge, no done, count=4, busy=0.
REQ-035 WRAP_W=2, mode=1, limit=0, 6 RUN cycles -> wraps saturates at 3; limit changed to 7 mid-run -> no effect.
REQ-036 reset pulsed low at count=6 during RUN -> immediate IDLE, done=0, wraps=0; start ignored during DONE and while busy.
